// File: rtl/l2_cache_control_pkg.sv
// l2_cache_control_pkg: shared L2 controller state type, way count and way helpers.
package l2_cache_control_pkg;
  localparam int L2_WAYS = 4;
  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} lc3b_l2_state;
  function automatic logic [L2_WAYS-1:0] way_onehot(input logic [1:0] w);
    logic [L2_WAYS-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction
  function automatic logic [1:0] lowest_set(input logic [L2_WAYS-1:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/l2_cache_control_victim_select.sv
// l2_victim_select: picks the lowest invalid way, falling back to the LRU victim when the set is full.
module l2_victim_select
  import l2_cache_control_pkg::*;
(
  input  logic [L2_WAYS-1:0] valid,
  input  logic [1:0]         lru_way,
  output logic [1:0]         victim
);
  assign victim = (&valid) ? lru_way : lowest_set(~valid);
endmodule

// File: rtl/l2_cache_control.sv
// l2_cache_control: L2 control FSM sequencing tag compare, dirty writeback and line allocate.
// Defining L2_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module l2_cache_control
  import l2_cache_control_pkg::*;
#(
  parameter int NUM_WAYS  = L2_WAYS,
  parameter int CNT_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic [NUM_WAYS-1:0] hit,
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [NUM_WAYS-1:0] dirty,
  input  logic [1:0]          lru_way,
  output logic                lru_write,
  output logic [1:0]          way_sel,
  output logic [NUM_WAYS-1:0] load_line,
  output logic [NUM_WAYS-1:0] set_dirty,
  output logic [NUM_WAYS-1:0] clr_dirty,
  output logic                datain_sel,
  output logic                pmem_addr_sel,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp
`ifdef L2_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`endif
);
  lc3b_l2_state r_state, w_next;
  logic [1:0] r_victim, w_victim, w_hit_way;
  logic       r_refill, w_req, w_hit;
  assign w_req     = mem_read | mem_write;
  assign w_hit     = |hit;
  assign w_hit_way = lowest_set(hit);
  l2_victim_select u_victim (
    .valid   (valid),
    .lru_way (lru_way),
    .victim  (w_victim)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_victim <= '0;
      r_refill <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_victim <= (r_state == COMPARE && w_req && !w_hit) ? w_victim : r_victim;
      r_refill <= (w_next == IDLE) ? 1'b0 : (r_state == ALLOCATE && pmem_resp) ? 1'b1 : r_refill;
    end
  end
  always_comb begin
    w_next        = r_state;
    mem_resp      = 1'b0;
    lru_write     = 1'b0;
    way_sel       = '0;
    load_line     = '0;
    set_dirty     = '0;
    clr_dirty     = '0;
    datain_sel    = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    case (r_state)
      IDLE: w_next = w_req ? COMPARE : IDLE;
      COMPARE: begin
        if (!w_req) begin
          w_next = IDLE;
        end else if (w_hit) begin
          w_next     = IDLE;
          way_sel    = w_hit_way;
          mem_resp   = 1'b1;
          lru_write  = 1'b1;
          load_line  = mem_write ? way_onehot(w_hit_way) : '0;
          set_dirty  = mem_write ? way_onehot(w_hit_way) : '0;
          datain_sel = mem_write;
        end else begin
          w_next = (valid[w_victim] && dirty[w_victim]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        way_sel       = r_victim;
        pmem_addr_sel = 1'b1;
        pmem_write    = !reset;
        clr_dirty     = pmem_resp ? way_onehot(r_victim) : '0;
        w_next        = pmem_resp ? ALLOCATE : WRITEBACK;
      end
      ALLOCATE: begin
        way_sel   = r_victim;
        pmem_read = !reset;
        load_line = pmem_resp ? way_onehot(r_victim) : '0;
        clr_dirty = pmem_resp ? way_onehot(r_victim) : '0;
        w_next    = pmem_resp ? COMPARE : ALLOCATE;
      end
      default: w_next = IDLE;
    endcase
  end
  a_onehot_hit: assert property (@(posedge clk) disable iff (reset)
    (r_state == COMPARE && w_req) |-> $onehot0(hit))
    else $warning("l2_cache_control: multi-hot hit vector %b", hit);
`ifdef L2_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_hit_cnt, r_miss_cnt, r_wb_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (r_state == COMPARE && w_req && w_hit && !r_refill && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
      if (r_state == COMPARE && w_req && !w_hit && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
      if (r_state == COMPARE && w_next == WRITEBACK && !(&r_wb_cnt)) r_wb_cnt <= r_wb_cnt + CNT_WIDTH'(1);
    end
  end
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
  assign wb_count   = r_wb_cnt;
`endif
endmodule

// File: tb/tb_l2_cache_control.sv
// tb_l2_cache_control: per-cycle trace model of L2 control transactions, directed cases plus random ones.
module tb_l2_cache_control;
  typedef struct packed {
    logic       mem_resp, lru_write;
    logic [1:0] way_sel;
    logic [3:0] load_line, set_dirty, clr_dirty;
    logic       datain_sel, pmem_addr_sel, pmem_read, pmem_write;
  } out_t;
  typedef struct packed {
    logic       rd, wr;
    logic [3:0] hit, valid, dirty;
    logic [1:0] lru;
    logic       presp;
  } in_t;
  typedef struct {
    string nm;
    in_t   i;
    out_t  o;
  } vec_t;
  logic clk = 1'b0, reset;
  logic mem_read, mem_write, mem_resp, lru_write, datain_sel, pmem_addr_sel, pmem_read, pmem_write, pmem_resp;
  logic [3:0] hit, valid, dirty, load_line, set_dirty, clr_dirty;
  logic [1:0] lru_way, way_sel;
`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif
  int n_chk = 0, n_fail = 0;
  int m_hit = 0, m_miss = 0, m_wb = 0;
  vec_t q[$];
  always #5 clk = ~clk;
  l2_cache_control dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit(hit), .valid(valid), .dirty(dirty), .lru_way(lru_way), .lru_write(lru_write),
    .way_sel(way_sel), .load_line(load_line), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
    .datain_sel(datain_sel), .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_resp(pmem_resp)
`ifdef L2_PERF_CNT_EN
    , .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
`endif
  );
  function automatic logic [3:0] oh(input logic [1:0] w);
    return 4'b0001 << w;
  endfunction
  function automatic out_t cur_out();
    out_t o;
    o.mem_resp = mem_resp; o.lru_write = lru_write; o.way_sel = way_sel;
    o.load_line = load_line; o.set_dirty = set_dirty; o.clr_dirty = clr_dirty;
    o.datain_sel = datain_sel; o.pmem_addr_sel = pmem_addr_sel;
    o.pmem_read = pmem_read; o.pmem_write = pmem_write;
    return o;
  endfunction
  function automatic out_t resp_out(input logic [1:0] w, input logic wr);
    out_t o;
    o = '0;
    o.mem_resp = 1'b1; o.lru_write = 1'b1; o.way_sel = w;
    if (wr) begin
      o.load_line = oh(w); o.set_dirty = oh(w); o.datain_sel = 1'b1;
    end
    return o;
  endfunction
  task automatic check(input string nm, input out_t got, input out_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask
  task automatic check_int(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  task automatic drive(input in_t i);
    mem_read = i.rd; mem_write = i.wr; hit = i.hit; valid = i.valid;
    dirty = i.dirty; lru_way = i.lru; pmem_resp = i.presp;
  endtask
  task automatic apply_q();
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      drive(v.i);
      @(negedge clk);
      check(v.nm, cur_out(), v.o);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check_counters(input string nm);
`ifdef L2_PERF_CNT_EN
    check_int({nm, " hit_count"}, hit_count, m_hit);
    check_int({nm, " miss_count"}, miss_count, m_miss);
    check_int({nm, " wb_count"}, wb_count, m_wb);
`endif
  endtask
  // One upstream request expanded into the cycle trace its outputs must follow.
  // drop: 0 none, 1 request gone in COMPARE, 2 gone at WRITEBACK start, 3 gone at ALLOCATE start.
  task automatic build(input string nm, input logic rd, input logic wr, input logic [3:0] hv,
                       input logic [3:0] va, input logic [3:0] di, input logic [1:0] lru,
                       input int wbw, input int alw, input int drop);
    vec_t v;
    logic [1:0] vic, hw;
    logic req_rd, req_wr;
    v.nm = {nm, " idle"};
    v.i = '{rd: rd, wr: wr, hit: hv, valid: va, dirty: di, lru: lru, presp: 1'($urandom)};
    v.o = '0;
    q.push_back(v);
    v.nm = {nm, " compare"};
    v.i.presp = 1'($urandom);
    if (drop == 1) begin
      v.i.rd = 1'b0; v.i.wr = 1'b0;
      q.push_back(v);
      return;
    end
    hw = 2'd0;
    for (int k = 3; k >= 0; k--) if (hv[k]) hw = 2'(k);
    if (hv != 4'b0) begin
      v.o = resp_out(hw, wr);
      q.push_back(v);
      m_hit++;
      return;
    end
    q.push_back(v);
    m_miss++;
    vic = lru;
    for (int k = 3; k >= 0; k--) if (!va[k]) vic = 2'(k);
    req_rd = rd; req_wr = wr;
    if (va[vic] && di[vic]) begin
      m_wb++;
      if (drop == 2) begin req_rd = 1'b0; req_wr = 1'b0; end
      for (int k = 0; k <= wbw; k++) begin
        v.nm = {nm, " writeback"};
        v.i.rd = req_rd; v.i.wr = req_wr; v.i.presp = (k == wbw);
        v.o = '0; v.o.way_sel = vic; v.o.pmem_addr_sel = 1'b1; v.o.pmem_write = 1'b1;
        if (k == wbw) v.o.clr_dirty = oh(vic);
        q.push_back(v);
      end
    end
    if (drop >= 2) begin req_rd = 1'b0; req_wr = 1'b0; end
    for (int k = 0; k <= alw; k++) begin
      v.nm = {nm, " allocate"};
      v.i.rd = req_rd; v.i.wr = req_wr; v.i.presp = (k == alw);
      v.o = '0; v.o.way_sel = vic; v.o.pmem_read = 1'b1;
      if (k == alw) begin v.o.load_line = oh(vic); v.o.clr_dirty = oh(vic); end
      q.push_back(v);
    end
    v.nm = {nm, " recompare"};
    v.i.hit = oh(vic); v.i.presp = 1'($urandom);
    v.o = (req_rd || req_wr) ? resp_out(vic, req_wr) : out_t'('0);
    q.push_back(v);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    drive('0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset outputs", cur_out(), '0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hit = 0; m_miss = 0; m_wb = 0;
    check_counters("after reset");
  endtask
  initial begin
    logic [1:0] w;
    logic [3:0] hv, va;
    int sel, dsel;
    do_reset();
    build("dirty miss", 1, 0, 4'b0000, 4'b1111, 4'b1000, 2'd3, 3, 2, 0); apply_q();
    check_counters("dirty miss");
    build("read hit", 1, 0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 0, 0, 0); apply_q();
    build("write hit", 0, 1, 4'b0001, 4'b0001, 4'b0000, 2'd1, 0, 0, 0); apply_q();
    build("clean miss", 1, 0, 4'b0000, 4'b1011, 4'b1011, 2'd0, 0, 5, 0); apply_q();
    build("withdraw compare", 1, 0, 4'b0000, 4'b1111, 4'b1111, 2'd1, 0, 0, 1); apply_q();
    build("rd and wr", 1, 1, 4'b1000, 4'b1000, 4'b0000, 2'd0, 0, 0, 0); apply_q();
    build("withdraw alloc", 0, 1, 4'b0000, 4'b0111, 4'b0111, 2'd2, 1, 2, 3); apply_q();
    check_counters("directed");
    // reset in the third ALLOCATE wait cycle of a clean miss to way 0
    build("pre-reset", 1, 0, 4'b0000, 4'b1110, 4'b0000, 2'd2, 0, 9, 0);
    for (int k = 0; k < 4; k++) begin
      vec_t v;
      v = q.pop_front();
      drive(v.i);
      @(negedge clk);
      check(v.nm, cur_out(), v.o);
      @(posedge clk);
      #1;
    end
    q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("reset mid-allocate pmem drop", cur_out(), '0);
    @(posedge clk);
    #1;
    reset = 1'b0; mem_read = 1'b0; pmem_resp = 1'b1;
    m_hit = 0; m_miss = 0; m_wb = 0;
    @(negedge clk);
    check("post-reset idle late resp", cur_out(), '0);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    check("post-reset still idle", cur_out(), '0);
    @(posedge clk);
    #1;
    check_counters("reset mid-allocate");
    build("post-reset read hit", 1, 0, 4'b0010, 4'b0010, 4'b0000, 2'd0, 0, 0, 0); apply_q();
    for (int n = 0; n < 300; n++) begin
      va = 4'($urandom);
      hv = 4'b0;
      if ($urandom_range(0, 1) == 1) begin
        w = 2'($urandom);
        hv = oh(w);
        va[w] = 1'b1;
      end
      sel = $urandom_range(0, 2);
      dsel = $urandom_range(0, 9);
      build("random", sel != 1, sel != 0, hv, va, 4'($urandom), 2'($urandom),
            $urandom_range(0, 4), $urandom_range(0, 4), dsel < 3 ? dsel + 1 : 0);
      apply_q();
      check_counters("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
